multicycle_core: RTL and testbench

Parametrised multi-cycle register-file processor core: accepts one instruction word at a time over a valid/ready port, sequences it through up to four steps (T0–T3) over a single internal bus, and executes it on an accumulator/result-register ALU. It succeeds the fixed 10-bit, 4-register lab datapath. It generalises data width and register count, and adds:

- input handshaking
- explicit done/err pulses
- zero/carry flags
- shift operations
- a read-only peek port

---
 rtl/mc_pkg.sv | 38 +++
 rtl/mc_alu.sv | 43 ++++
 rtl/multicycle_core.sv | 152 +++++++++++++++
 tb/tb_multicycle_core.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle register-file core.
package mc_pkg;

   localparam int OPC_W = 4;

   // Instruction opcodes; 0xA..0xF are illegal and raise err.
   typedef enum logic [OPC_W-1:0] {
      OP_LOAD = 4'h0,
      OP_MOV  = 4'h1,
      OP_ADD  = 4'h2,
      OP_SUB  = 4'h3,
      OP_AND  = 4'h4,
      OP_OR   = 4'h5,
      OP_XOR  = 4'h6,
      OP_NOT  = 4'h7,
      OP_SLL1 = 4'h8,
      OP_SRL1 = 4'h9
   } opcode_e;

   // Instruction step counter values.
   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } step_e;

   // Opcodes the core knows how to execute.
   function automatic logic isLegal(input logic [OPC_W-1:0] op);
      return (op <= OP_SRL1);
   endfunction

   // ALU ops that take their second operand from regs[ry].
   function automatic logic isTwoOperand(input logic [OPC_W-1:0] op);
      return (op >= OP_ADD) && (op <= OP_XOR);
   endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU: result and carry/borrow for every ALU opcode.
module mc_alu
   import mc_pkg::*;
#(
   parameter int DATA_W = 10
) (
   input  logic [OPC_W-1:0]  FN,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   output logic [DATA_W-1:0] result,
   output logic              carry
);

   // Select the operation; logic ops and non-ALU codes report carry 0.
   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (FN)
         OP_ADD:  {carry, result} = {1'b0, A} + {1'b0, B};
         OP_SUB: begin
            result = A - B;
            carry  = (A < B);
         end
         OP_AND:  result = A & B;
         OP_OR:   result = A | B;
         OP_XOR:  result = A ^ B;
         OP_NOT:  result = ~A;
         OP_SLL1: begin
            result = {A[DATA_W-2:0], 1'b0};
            carry  = A[DATA_W-1];
         end
         OP_SRL1: begin
            result = {1'b0, A[DATA_W-1:1]};
            carry  = A[0];
         end
         default: begin
            result = '0;
            carry  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle register-file core: one instruction at a time over a
// valid/ready port, sequenced through T0..T3 on a single internal bus.
module multicycle_core
   import mc_pkg::*;
#(
   parameter  int DATA_W = 10,
   parameter  int NREGS  = 4,
   localparam int RA_W   = $clog2(NREGS)
) (
   input  logic              CLK,
   input  logic              RSTb,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [RA_W-1:0]   peek_addr,
   output logic [DATA_W-1:0] peek_data,
   output logic [DATA_W-1:0] bus_out,
   output logic [1:0]        step,
   output logic              done,
   output logic              err,
   output logic              flag_z,
   output logic              flag_c
);

   // Only opcode, rx and ry are kept from the instruction word.
   localparam int IR_W = OPC_W + 2 * RA_W;

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] g_q;
   logic [IR_W-1:0]   ir_q;
   logic [IR_W-1:0]   ir_d;
   step_e             step_q;
   logic              done_q;
   logic              err_q;
   logic              flag_z_q;
   logic              flag_c_q;

   logic [OPC_W-1:0]  inOp;
   logic [OPC_W-1:0]  irOp;
   logic [RA_W-1:0]   irRx;
   logic [RA_W-1:0]   irRy;
   logic [DATA_W-1:0] busValue;
   logic [DATA_W-1:0] aluResult;
   logic              aluCarry;

   assign inOp = in_data[DATA_W-1 -: OPC_W];
   assign ir_d = {inOp, in_data[2*RA_W-1:RA_W], in_data[RA_W-1:0]};
   assign irOp = ir_q[IR_W-1 -: OPC_W];
   assign irRx = ir_q[2*RA_W-1:RA_W];
   assign irRy = ir_q[RA_W-1:0];

   assign in_ready  = (step_q == T0) || ((step_q == T1) && (irOp == OP_LOAD));
   assign peek_data = regs_q[peek_addr];
   assign bus_out   = busValue;
   assign step      = step_q;
   assign done      = done_q;
   assign err       = err_q;
   assign flag_z    = flag_z_q;
   assign flag_c    = flag_c_q;

   // Drive the shared bus from the source the current step needs.
   always_comb begin
      busValue = in_data;
      case (step_q)
         T0: busValue = in_data;
         T1: begin
            if (irOp == OP_LOAD) begin
               busValue = in_data;
            end else if (irOp == OP_MOV) begin
               busValue = regs_q[irRy];
            end else begin
               busValue = regs_q[irRx];
            end
         end
         T2: busValue = isTwoOperand(irOp) ? regs_q[irRy] : a_q;
         T3: busValue = g_q;
         default: busValue = in_data;
      endcase
   end

   mc_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .FN     (irOp),
      .A      (a_q),
      .B      (busValue),
      .result (aluResult),
      .carry  (aluCarry)
   );

   // Step sequencer, datapath registers and registered status pulses.
   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         step_q   <= T0;
         ir_q     <= '0;
         a_q      <= '0;
         g_q      <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         flag_z_q <= 1'b0;
         flag_c_q <= 1'b0;
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (step_q)
            T0: begin
               if (in_valid) begin
                  ir_q <= ir_d;
                  if (isLegal(inOp)) begin
                     step_q <= T1;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            T1: begin
               if (irOp == OP_LOAD) begin
                  if (in_valid) begin
                     regs_q[irRx] <= busValue;
                     done_q       <= 1'b1;
                     step_q       <= T0;
                  end
               end else if (irOp == OP_MOV) begin
                  regs_q[irRx] <= busValue;
                  done_q       <= 1'b1;
                  step_q       <= T0;
               end else begin
                  a_q    <= busValue;
                  step_q <= T2;
               end
            end
            T2: begin
               g_q      <= aluResult;
               flag_z_q <= (aluResult == '0);
               flag_c_q <= aluCarry;
               step_q   <= T3;
            end
            T3: begin
               regs_q[irRx] <= busValue;
               done_q       <= 1'b1;
               step_q       <= T0;
            end
            default: step_q <= T0;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_core.sv
// Directed self-checking bench for multicycle_core (DATA_W=10, NREGS=4).
module tb_multicycle_core;

   localparam int DATA_W = 10;
   localparam int NREGS  = 4;

   logic              CLK = 1'b0;
   logic              RSTb = 1'b1;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [1:0]        peek_addr = '0;
   logic [DATA_W-1:0] peek_data;
   logic [DATA_W-1:0] bus_out;
   logic [1:0]        step;
   logic              done;
   logic              err;
   logic              flag_z;
   logic              flag_c;

   int checks = 0;
   int failures = 0;

   multicycle_core #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS)
   ) dut (
      .CLK       (CLK),
      .RSTb      (RSTb),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .peek_addr (peek_addr),
      .peek_data (peek_data),
      .bus_out   (bus_out),
      .step      (step),
      .done      (done),
      .err       (err),
      .flag_z    (flag_z),
      .flag_c    (flag_c)
   );

   // Free-running 10-unit clock.
   always #5 CLK = ~CLK;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Read a register through the peek port.
   task automatic readReg(input logic [1:0] r, output logic [DATA_W-1:0] v);
      peek_addr = r;
      #1;
      v = peek_data;
   endtask

   // Two-beat LOAD of register r; returns in the done cycle.
   task automatic applyLoad(input logic [1:0] r, input logic [DATA_W-1:0] v);
      in_data  = {4'h0, 2'b00, r, 2'b00};
      in_valid = 1'b1;
      tick();
      in_data = v;
      tick();
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   // Issue one instruction and let the given number of further edges pass.
   task automatic applyStimulus(input logic [DATA_W-1:0] instr, input int edges);
      in_data  = instr;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_data  = '0;
      repeat (edges) tick();
   endtask

   task automatic test_reset();
      logic [DATA_W-1:0] v;
      #2;
      RSTb = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      RSTb = 1'b1;
      #1;
      for (int i = 0; i < NREGS; i++) begin
         readReg(2'(i), v);
         checks++;
         if (v !== 10'h000) begin
            failures++;
            $display("[TB] FAIL reset_reg%0d: got %h expected 000", i, v);
         end
      end
      checks++;
      if ({step, in_ready, done, err, flag_z, flag_c} !== 7'b00_1_0_0_0_0) begin
         failures++;
         $display("[TB] FAIL reset_status: got step=%0d rdy=%b done=%b err=%b z=%b c=%b expected 0 1 0 0 0 0",
                  step, in_ready, done, err, flag_z, flag_c);
      end
      tick();
   endtask

   task automatic test_load();
      logic [DATA_W-1:0] v;
      in_data  = 10'h004;
      in_valid = 1'b1;
      tick();
      in_data = 10'h155;
      #1;
      checks++;
      if ({step, in_ready} !== 3'b01_1 || bus_out !== 10'h155) begin
         failures++;
         $display("[TB] FAIL load_t1: got step=%0d rdy=%b bus=%h expected 1 1 155", step, in_ready, bus_out);
      end
      tick();
      readReg(2'd1, v);
      checks++;
      if (v !== 10'h155) begin
         failures++;
         $display("[TB] FAIL load_r1: got %h expected 155", v);
      end
      checks++;
      if ({done, step, in_ready} !== 4'b1_00_1) begin
         failures++;
         $display("[TB] FAIL load_done: got done=%b step=%0d rdy=%b expected 1 0 1", done, step, in_ready);
      end
      in_data = 10'h049;
      tick();
      in_valid = 1'b0;
      in_data  = '0;
      readReg(2'd2, v);
      checks++;
      if (done !== 1'b0 || step !== 2'd1 || bus_out !== 10'h155 || v !== 10'h000) begin
         failures++;
         $display("[TB] FAIL mov_t1: got done=%b step=%0d bus=%h r2=%h expected 0 1 155 000", done, step, bus_out, v);
      end
      tick();
      readReg(2'd2, v);
      checks++;
      if (v !== 10'h155 || done !== 1'b1 || step !== 2'd0) begin
         failures++;
         $display("[TB] FAIL mov_write: got r2=%h done=%b step=%0d expected 155 1 0", v, done, step);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL mov_done_width: got %b expected 0", done);
      end
   endtask

   task automatic test_add();
      logic [DATA_W-1:0] v;
      applyLoad(2'd1, 10'h3FF);
      applyLoad(2'd2, 10'h001);
      in_data  = 10'h086;
      in_valid = 1'b1;
      tick();
      in_data = 10'h3C0;
      checks++;
      if (step !== 2'd1 || bus_out !== 10'h3FF) begin
         failures++;
         $display("[TB] FAIL add_t1: got step=%0d bus=%h expected 1 3ff", step, bus_out);
      end
      tick();
      checks++;
      if (step !== 2'd2 || bus_out !== 10'h001) begin
         failures++;
         $display("[TB] FAIL add_t2: got step=%0d bus=%h expected 2 001", step, bus_out);
      end
      tick();
      in_valid = 1'b0;
      in_data  = '0;
      readReg(2'd1, v);
      checks++;
      if (step !== 2'd3 || flag_z !== 1'b1 || flag_c !== 1'b1 || bus_out !== 10'h000 || v !== 10'h3FF) begin
         failures++;
         $display("[TB] FAIL add_t3: got step=%0d z=%b c=%b bus=%h r1=%h expected 3 1 1 000 3ff",
                  step, flag_z, flag_c, bus_out, v);
      end
      tick();
      readReg(2'd1, v);
      checks++;
      if (v !== 10'h000 || done !== 1'b1 || err !== 1'b0 || step !== 2'd0) begin
         failures++;
         $display("[TB] FAIL add_write: got r1=%h done=%b err=%b step=%0d expected 000 1 0 0", v, done, err, step);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL add_done_width: got %b expected 0", done);
      end
   endtask

   task automatic test_same_reg();
      logic [DATA_W-1:0] v;
      applyStimulus(10'h08A, 3);
      readReg(2'd2, v);
      checks++;
      if (v !== 10'h002 || flag_z !== 1'b0 || flag_c !== 1'b0) begin
         failures++;
         $display("[TB] FAIL add_rr: got r2=%h z=%b c=%b expected 002 0 0", v, flag_z, flag_c);
      end
      applyStimulus(10'h0CA, 3);
      readReg(2'd2, v);
      checks++;
      if (v !== 10'h000 || flag_z !== 1'b1 || flag_c !== 1'b0) begin
         failures++;
         $display("[TB] FAIL sub_rr: got r2=%h z=%b c=%b expected 000 1 0", v, flag_z, flag_c);
      end
   endtask

   task automatic test_sub_shift();
      logic [DATA_W-1:0] v;
      applyLoad(2'd0, 10'h005);
      applyLoad(2'd3, 10'h007);
      applyStimulus(10'h0C3, 3);
      readReg(2'd0, v);
      checks++;
      if (v !== 10'h3FE || flag_z !== 1'b0 || flag_c !== 1'b1 || done !== 1'b1) begin
         failures++;
         $display("[TB] FAIL sub: got r0=%h z=%b c=%b done=%b expected 3fe 0 1 1", v, flag_z, flag_c, done);
      end
      in_data  = 10'h240;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_data  = '0;
      tick();
      checks++;
      if (step !== 2'd2 || bus_out !== 10'h3FE) begin
         failures++;
         $display("[TB] FAIL srl_t2_bus: got step=%0d bus=%h expected 2 3fe", step, bus_out);
      end
      tick();
      tick();
      readReg(2'd0, v);
      checks++;
      if (v !== 10'h1FF || flag_z !== 1'b0 || flag_c !== 1'b0 || done !== 1'b1) begin
         failures++;
         $display("[TB] FAIL srl: got r0=%h z=%b c=%b done=%b expected 1ff 0 0 1", v, flag_z, flag_c, done);
      end
   endtask

   task automatic test_load_stall();
      logic [DATA_W-1:0] v;
      applyLoad(2'd3, 10'h2A5);
      in_data  = 10'h00C;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_data  = 10'h111;
      for (int i = 0; i < 5; i++) begin
         tick();
         readReg(2'd3, v);
         checks++;
         if (step !== 2'd1 || v !== 10'h2A5 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stall_%0d: got step=%0d r3=%h done=%b expected 1 2a5 0", i, step, v, done);
         end
      end
      #2;
      RSTb = 1'b0;
      #1;
      readReg(2'd3, v);
      checks++;
      if (step !== 2'd0 || in_ready !== 1'b1 || v !== 10'h000 || done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL stall_reset: got step=%0d rdy=%b r3=%h done=%b expected 0 1 000 0", step, in_ready, v, done);
      end
      in_data = '0;
      tick();
      RSTb = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (done !== 1'b0 || step !== 2'd0) begin
            failures++;
            $display("[TB] FAIL post_reset_%0d: got done=%b step=%0d expected 0 0", i, done, step);
         end
      end
   endtask

   task automatic test_illegal();
      logic [DATA_W-1:0] v1;
      logic [DATA_W-1:0] v2;
      applyLoad(2'd1, 10'h3FF);
      applyLoad(2'd2, 10'h001);
      applyStimulus(10'h086, 3);
      in_data  = 10'h3C0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_data  = '0;
      readReg(2'd1, v1);
      readReg(2'd2, v2);
      checks++;
      if (err !== 1'b1 || done !== 1'b0 || step !== 2'd0 || in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL illegal_pulse: got err=%b done=%b step=%0d rdy=%b expected 1 0 0 1", err, done, step, in_ready);
      end
      checks++;
      if (v1 !== 10'h000 || v2 !== 10'h001 || flag_z !== 1'b1 || flag_c !== 1'b1) begin
         failures++;
         $display("[TB] FAIL illegal_state: got r1=%h r2=%h z=%b c=%b expected 000 001 1 1", v1, v2, flag_z, flag_c);
      end
      tick();
      checks++;
      if (err !== 1'b0 || done !== 1'b0 || step !== 2'd0) begin
         failures++;
         $display("[TB] FAIL illegal_after: got err=%b done=%b step=%0d expected 0 0 0", err, done, step);
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      $display("[TB] multicycle_core directed test start");
      test_reset();
      test_load();
      test_add();
      test_same_reg();
      test_sub_shift();
      test_load_stall();
      test_illegal();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
